// File: rtl/comporta_pkg.sv
// comporta_pkg: state codes, direction constants and width helper for the floodgate controller
package comporta_pkg;
    localparam logic [3:0] ST_INICIAL = 4'd0;
    localparam logic [3:0] ST_PREPARA = 4'd1;
    localparam logic [3:0] ST_PASSO   = 4'd2;
    localparam logic [3:0] ST_ESPERA  = 4'd3;
    localparam logic [3:0] ST_PARADA  = 4'd4;
    localparam logic [3:0] ST_EMERG   = 4'd5;
    localparam logic DIR_ABRE  = 1'b1;
    localparam logic DIR_FECHA = 1'b0;
    function automatic int largura(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/comporta_controlador_if.sv
// comporta_controlador_if: operator inputs and gate status outputs of the floodgate controller
interface comporta_controlador_if #(parameter int POS_W = 3);
    logic             abrirComporta;
    logic [POS_W-1:0] alvo;
    logic             emergencia;
    logic [POS_W-1:0] posicao;
    logic             direcao;
    logic             movendo;
    logic             aberta;
    logic             fechada;
    logic [3:0]       dbEstado;
    modport master (output abrirComporta, alvo, emergencia,
                    input  posicao, direcao, movendo, aberta, fechada, dbEstado);
    modport slave  (input  abrirComporta, alvo, emergencia,
                    output posicao, direcao, movendo, aberta, fechada, dbEstado);
endinterface

// File: rtl/comporta_temporizador.sv
// comporta_temporizador: interval counter, cleared by zera, advanced by conta, fim at MAX-1
module comporta_temporizador
    import comporta_pkg::*;
#(
    parameter int MAX = 1000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     zera,
    input  logic                     conta,
    output logic [largura(MAX)-1:0]  valor,
    output logic                     fim
);
    localparam int W = largura(MAX);
    localparam logic [W-1:0] LIM = W'(MAX - 1);
    logic [W-1:0] r_cnt;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_cnt <= '0;
        else if (zera) r_cnt <= '0;
        else if (conta) r_cnt <= (r_cnt == LIM) ? '0 : r_cnt + 1'b1;
    end
    assign valor = r_cnt;
    assign fim   = (r_cnt == LIM);
endmodule

// File: rtl/comporta_controlador.sv
// comporta_controlador: floodgate FSM with position counter, partial opening and emergency close
module comporta_controlador
    import comporta_pkg::*;
#(
    parameter int POS_W           = 3,
    parameter int POS_MAX         = 7,
    parameter int INTERVALO       = 1000,
    parameter int INTERVALO_EMERG = 250
) (
    input  logic                   clock,
    input  logic                   reset,
    comporta_controlador_if.slave  bus
);
    localparam int T_MAX = INTERVALO > INTERVALO_EMERG ? INTERVALO : INTERVALO_EMERG;
    localparam int TW    = largura(T_MAX);
    localparam logic [POS_W-1:0] P_MAX = POS_W'(POS_MAX);
    localparam logic [TW-1:0]    LIM_N = TW'(INTERVALO - 1);
    localparam logic [TW-1:0]    LIM_E = TW'(INTERVALO_EMERG - 1);

    logic [3:0]       r_estado;
    logic [POS_W-1:0] r_pos, r_alvo;
    logic             r_dir;
    logic [TW-1:0]    w_tempo;
    logic             w_fim, w_conta, w_zera, w_lim_n, w_lim_e;
    logic [POS_W-1:0] w_alvo_sat, w_t, w_t_prep;

    // The shared timer only produces fim for the longer interval; the other limit is compared directly.
    always_comb begin
        w_alvo_sat = (bus.alvo > P_MAX) ? P_MAX : bus.alvo;
        w_t        = bus.abrirComporta ? r_alvo : '0;
        w_t_prep   = bus.abrirComporta ? w_alvo_sat : '0;
        w_lim_n    = (INTERVALO >= INTERVALO_EMERG) ? w_fim : (w_tempo == LIM_N);
        w_lim_e    = (INTERVALO_EMERG >= INTERVALO) ? w_fim : (w_tempo == LIM_E);
        w_conta    = (r_estado == ST_ESPERA && !bus.emergencia && !w_lim_n) ||
                     (r_estado == ST_EMERG && r_pos != '0 && !w_lim_e);
        w_zera     = !w_conta;
    end

    comporta_temporizador #(.MAX(T_MAX)) u_temporizador (
        .clock (clock),
        .reset (reset),
        .zera  (w_zera),
        .conta (w_conta),
        .valor (w_tempo),
        .fim   (w_fim)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado <= ST_INICIAL;
            r_pos    <= '0;
            r_dir    <= DIR_FECHA;
            r_alvo   <= '0;
        end else if (bus.emergencia && r_estado != ST_EMERG) begin
            r_estado <= ST_EMERG;
        end else begin
            case (r_estado)
                ST_INICIAL: if (bus.abrirComporta) r_estado <= ST_PREPARA;
                ST_PREPARA: begin
                    r_alvo <= w_alvo_sat;
                    if (r_pos == w_t_prep) r_estado <= (w_t_prep == '0) ? ST_INICIAL : ST_PARADA;
                    else begin
                        r_estado <= ST_PASSO;
                        r_dir    <= (r_pos < w_t_prep);
                    end
                end
                ST_PASSO: begin
                    r_pos    <= (r_dir == DIR_ABRE) ? ((r_pos != P_MAX) ? r_pos + 1'b1 : r_pos)
                                                    : ((r_pos != '0) ? r_pos - 1'b1 : r_pos);
                    r_estado <= ST_ESPERA;
                end
                ST_ESPERA: if (w_lim_n) begin
                    if (r_pos == w_t) r_estado <= (w_t == '0) ? ST_INICIAL : ST_PARADA;
                    else begin
                        r_estado <= ST_PASSO;
                        r_dir    <= (r_pos < w_t);
                    end
                end
                ST_PARADA: begin
                    if (!bus.abrirComporta) begin
                        r_estado <= ST_PASSO;
                        r_dir    <= DIR_FECHA;
                    end else if (w_alvo_sat != r_alvo) r_estado <= ST_PREPARA;
                end
                ST_EMERG: begin
                    if (r_pos == '0) begin
                        if (!bus.emergencia) r_estado <= ST_INICIAL;
                    end else if (w_lim_e) begin
                        r_pos <= r_pos - 1'b1;
                        r_dir <= DIR_FECHA;
                    end
                end
                default: r_estado <= ST_INICIAL;
            endcase
        end
    end

    assign bus.posicao  = r_pos;
    assign bus.direcao  = r_dir;
    assign bus.movendo  = (r_estado == ST_PASSO) || (r_estado == ST_ESPERA) ||
                          (r_estado == ST_EMERG && r_pos != '0);
    assign bus.aberta   = (r_estado == ST_PARADA);
    assign bus.fechada  = (r_pos == '0);
    assign bus.dbEstado = r_estado;
endmodule

// File: tb/tb_comporta_controlador.sv
// tb_comporta_controlador: scoreboard bench; expected values queued with their due cycle when stimulus is driven
module tb_comporta_controlador;
    localparam int POS = 0, DIR = 1, MOV = 2, ABE = 3, FEC = 4, EST = 5;

    typedef struct {
        int    cyc;
        string tag;
        int    sel;
        int    exp;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   k, c, e;
    exp_t sb[$];

    comporta_controlador_if #(.POS_W(3)) bus ();

    comporta_controlador #(.POS_W(3), .POS_MAX(5), .INTERVALO(4), .INTERVALO_EMERG(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int obs(input int sel);
        case (sel)
            POS:     return int'(bus.posicao);
            DIR:     return int'(bus.direcao);
            MOV:     return int'(bus.movendo);
            ABE:     return int'(bus.aberta);
            FEC:     return int'(bus.fechada);
            default: return int'(bus.dbEstado);
        endcase
    endfunction

    task automatic add(input int at, input string tag, input int sel, input int exp);
        exp_t x;
        x.cyc = at;
        x.tag = tag;
        x.sel = sel;
        x.exp = exp;
        sb.push_back(x);
    endtask

    always @(negedge clock) begin
        exp_t x;
        while (sb.size() != 0 && sb[0].cyc <= cyc) begin
            x = sb.pop_front();
            check(x.tag, obs(x.sel), x.exp);
        end
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) begin
            @(posedge clock);
            #1;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        repeat (3) @(posedge clock);
        #1;
    endtask

    initial begin
        bus.abrirComporta = 1'b0;
        bus.alvo          = '0;
        bus.emergencia    = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_pos", obs(POS), 0);
        check("rst_dir", obs(DIR), 0);
        check("rst_mov", obs(MOV), 0);
        check("rst_abe", obs(ABE), 0);
        check("rst_fec", obs(FEC), 1);
        check("rst_est", obs(EST), 0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;

        // open to 3
        k = cyc;
        bus.alvo = 3'd3;
        bus.abrirComporta = 1'b1;
        add(k + 1, "op_prep", EST, 1);
        add(k + 2, "op_passo", EST, 2);
        add(k + 2, "op_fec_hi", FEC, 1);
        add(k + 3, "op_pos1", POS, 1);
        add(k + 3, "op_fec_lo", FEC, 0);
        add(k + 3, "op_mov", MOV, 1);
        add(k + 3, "op_dir", DIR, 1);
        add(k + 8, "op_pos2", POS, 2);
        add(k + 13, "op_pos3", POS, 3);
        add(k + 16, "op_abe_lo", ABE, 0);
        add(k + 16, "op_esp", EST, 3);
        add(k + 17, "op_abe_hi", ABE, 1);
        add(k + 17, "op_parada", EST, 4);
        add(k + 17, "op_mov_lo", MOV, 0);
        add(k + 20, "op_hold", POS, 3);
        drain();

        // close from 3
        c = cyc;
        bus.abrirComporta = 1'b0;
        add(c + 1, "cl_passo", EST, 2);
        add(c + 2, "cl_pos2", POS, 2);
        add(c + 2, "cl_dir", DIR, 0);
        add(c + 7, "cl_pos1", POS, 1);
        add(c + 12, "cl_pos0", POS, 0);
        add(c + 12, "cl_fec", FEC, 1);
        add(c + 15, "cl_esp", EST, 3);
        add(c + 16, "cl_ini", EST, 0);
        add(c + 16, "cl_mov", MOV, 0);
        drain();

        // emergency while opening at 3
        k = cyc;
        bus.alvo = 3'd5;
        bus.abrirComporta = 1'b1;
        add(k + 3, "em_pos1", POS, 1);
        add(k + 13, "em_pos3", POS, 3);
        wait_cyc(k + 14);
        e = cyc;
        bus.emergencia = 1'b1;
        bus.abrirComporta = 1'b0;
        add(e + 1, "em_est", EST, 5);
        add(e + 1, "em_mov", MOV, 1);
        add(e + 2, "em_pos3b", POS, 3);
        add(e + 2, "em_dir1", DIR, 1);
        add(e + 3, "em_pos2", POS, 2);
        add(e + 3, "em_dir0", DIR, 0);
        add(e + 5, "em_pos1b", POS, 1);
        add(e + 7, "em_pos0", POS, 0);
        add(e + 7, "em_mov0", MOV, 0);
        add(e + 7, "em_fec", FEC, 1);
        add(e + 10, "em_hold", EST, 5);
        add(e + 10, "em_nowrap", POS, 0);
        wait_cyc(e + 10);
        bus.emergencia = 1'b0;
        add(e + 11, "em_exit", EST, 0);
        drain();

        // saturating target, then reversal while closing
        k = cyc;
        bus.alvo = 3'd7;
        bus.abrirComporta = 1'b1;
        add(k + 3, "sat_pos1", POS, 1);
        add(k + 18, "sat_pos4", POS, 4);
        add(k + 23, "sat_pos5", POS, 5);
        add(k + 26, "sat_esp", EST, 3);
        add(k + 27, "sat_abe", ABE, 1);
        add(k + 27, "sat_posA", POS, 5);
        add(k + 30, "sat_posB", POS, 5);
        add(k + 30, "sat_hold", EST, 4);
        drain();
        c = cyc;
        bus.abrirComporta = 1'b0;
        add(c + 2, "rv_pos4", POS, 4);
        add(c + 2, "rv_dir0", DIR, 0);
        add(c + 7, "rv_pos3", POS, 3);
        wait_cyc(c + 8);
        bus.abrirComporta = 1'b1;
        add(c + 10, "rv_pos3b", POS, 3);
        add(c + 11, "rv_dir1", DIR, 1);
        add(c + 11, "rv_passo", EST, 2);
        add(c + 12, "rv_pos4b", POS, 4);
        add(c + 17, "rv_pos5", POS, 5);
        add(c + 21, "rv_parada", EST, 4);
        add(c + 21, "rv_abe", ABE, 1);
        drain();

        // asynchronous reset during ESPERA at 4
        c = cyc;
        bus.abrirComporta = 1'b0;
        add(c + 2, "ar_pos4", POS, 4);
        wait_cyc(c + 3);
        reset = 1'b0;
        add(c + 3, "ar_pos", POS, 0);
        add(c + 3, "ar_est", EST, 0);
        add(c + 3, "ar_mov", MOV, 0);
        add(c + 3, "ar_fec", FEC, 1);
        wait_cyc(c + 5);
        reset = 1'b1;
        add(c + 9, "ar_idle_est", EST, 0);
        add(c + 9, "ar_idle_pos", POS, 0);
        drain();
        k = cyc;
        bus.alvo = 3'd1;
        bus.abrirComporta = 1'b1;
        add(k + 1, "ar_prep", EST, 1);
        add(k + 3, "ar_pos1", POS, 1);
        add(k + 6, "ar_esp", EST, 3);
        add(k + 7, "ar_parada", EST, 4);
        add(k + 7, "ar_abe", ABE, 1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
        $fatal(1);
    end
endmodule
